// File: rtl/ctrl_pkg.sv
// Shared encodings for the decode stage.
// Holds the opcode and funct encodings, the ALU operation enum and the
// packed control-bit bundle passed from the decoder to the stage register.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLLV = 3'b101,
    ALU_SRLV = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    branch_ne;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder.
// Ports:
//   instr          32-bit instruction word
//   ctrl           control bundle (illegal instructions get all-zero control)
//   rs1/rs2/wreg   source and destination register addresses
//   imm            immediate extended to DATA_W (DATA_W must be >= 16)
//   use_rs/use_rt  which source fields the instruction actually reads
module decode_comb
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr,
  output ctrl_t             ctrl,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        wreg,
  output logic [DATA_W-1:0] imm,
  output logic              use_rs,
  output logic              use_rt
);

  logic [5:0]        op, funct;
  logic [4:0]        rt, rd;
  logic [DATA_W-1:0] sext, zext;
  logic              r_ok;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign rs1   = instr[25:21];
  assign rs2   = rt;
  assign sext  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign zext  = {{(DATA_W-16){1'b0}}, instr[15:0]};

  // shamt field is not used by any supported instruction
  logic unused_shamt;
  assign unused_shamt = &{1'b0, instr[10:6]};

  always_comb begin
    ctrl   = '0;
    wreg   = '0;
    imm    = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    r_ok   = 1'b0;
    case (op)
      OP_R: begin
        r_ok = 1'b1;
        case (funct)
          F_ADD:   ctrl.alu_op = ALU_ADD;
          F_SUB:   ctrl.alu_op = ALU_SUB;
          F_AND:   ctrl.alu_op = ALU_AND;
          F_OR:    ctrl.alu_op = ALU_OR;
          F_XOR:   ctrl.alu_op = ALU_XOR;
          F_SLLV:  ctrl.alu_op = ALU_SLLV;
          F_SRLV:  ctrl.alu_op = ALU_SRLV;
          F_SLT:   ctrl.alu_op = ALU_SLT;
          default: r_ok = 1'b0;
        endcase
        if (r_ok) begin
          ctrl.reg_write = 1'b1;
          wreg           = rd;
          use_rs         = 1'b1;
          use_rt         = 1'b1;
        end else begin
          ctrl = '0;
          ctrl.illegal = 1'b1;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        wreg           = rt;
        use_rs         = 1'b1;
        case (op)
          OP_ADDI: begin ctrl.alu_op = ALU_ADD; imm = sext; end
          OP_ANDI: begin ctrl.alu_op = ALU_AND; imm = zext; end
          OP_ORI:  begin ctrl.alu_op = ALU_OR;  imm = zext; end
          default: begin ctrl.alu_op = ALU_XOR; imm = zext; end
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        wreg            = rt;
        imm             = sext;
        use_rs          = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        imm            = sext;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (op == OP_BNE);
        ctrl.alu_op    = ALU_SUB;
        imm            = sext;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // r0 is hardwired zero; a write to it is never a real write
    if (wreg == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage with load-use stall and flush.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        instruction handshake, in_instr the word
//   flush                    kills the registered bundle, blocks input
//   out_valid/out_ready      decoded-bundle handshake
//   out_*                    registered decoded fields
//   bubble_cnt               saturating count of load-use bubbles
module decode_stage
  import ctrl_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic              out_alu_src,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              out_branch,
  output logic              out_branch_ne,
  output logic [2:0]        out_alu_op,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_wreg,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t             dec_ctrl, q_ctrl;
  logic [4:0]        dec_rs1, dec_rs2, dec_wreg;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_use_rs, dec_use_rt;
  logic              hazard, accept;

  decode_comb #(.DATA_W(DATA_W)) u_dec (
    .instr  (in_instr),
    .ctrl   (dec_ctrl),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .wreg   (dec_wreg),
    .imm    (dec_imm),
    .use_rs (dec_use_rs),
    .use_rt (dec_use_rt)
  );

  // Load in the output register whose destination feeds the instruction
  // now offered: hold it back one cycle so the load data can be forwarded.
  assign hazard = (HAZARD_EN != 0) && out_valid && q_ctrl.mem_read &&
                  (out_wreg != 5'd0) &&
                  ((dec_use_rs && (dec_rs1 == out_wreg)) ||
                   (dec_use_rt && (dec_rs2 == out_wreg)));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      q_ctrl     <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
      out_wreg   <= '0;
      out_imm    <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q_ctrl    <= dec_ctrl;
      out_rs1   <= dec_rs1;
      out_rs2   <= dec_rs2;
      out_wreg  <= dec_wreg;
      out_imm   <= dec_imm;
    end else if (out_ready) begin
      // bundle drained with nothing behind it; a hazard here is a bubble
      out_valid <= 1'b0;
      if (hazard && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign out_reg_write  = q_ctrl.reg_write;
  assign out_alu_src    = q_ctrl.alu_src;
  assign out_mem_read   = q_ctrl.mem_read;
  assign out_mem_write  = q_ctrl.mem_write;
  assign out_mem_to_reg = q_ctrl.mem_to_reg;
  assign out_branch     = q_ctrl.branch;
  assign out_branch_ne  = q_ctrl.branch_ne;
  assign out_alu_op     = q_ctrl.alu_op;
  assign out_illegal    = q_ctrl.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 64, the width of the extended immediate; the value SHALL be at least 16.
REQ-002 Parameter CNT_W, default 16, the width of the stall-bubble counter.
REQ-003 Parameter HAZARD_EN, default 1; when set to 0, load-use stall detection SHALL be disabled.
REQ-004 Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in / out  1 / 1  instruction handshake.
- in_instr  in  32  fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- flush  in  1  branch-taken kill.
- out_valid / out_ready  out / in  1 / 1  decoded-bundle handshake.
- out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_branch_ne  out  1 each  control bits.
- out_alu_op  out  3  ALU operation.
- out_rs1, out_rs2, out_wreg  out  5 each  register addresses.
- out_imm  out  DATA_W  extended immediate.
- out_illegal  out  1  unsupported instruction flag.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

Function
REQ-005 Opcodes: R 000000, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101.
REQ-006 R-type funct values SHALL map to alu_op as follows: ADD 100000→000, SUB 100010→001, AND 100100→010, OR 100101→011, XOR 100110→100, SLLV 000100→101, SRLV 000110→110, SLT 101010→111.
REQ-007 Control bits SHALL be set per instruction class:
- R-type: reg_write=1.
- I-ALU ops: reg_write=1, alu_src=1.
- LW: reg_write=1, alu_src=1, mem_read=1, mem_to_reg=1, alu_op=ADD.
- SW: alu_src=1, mem_write=1, alu_op=ADD.
- BEQ/BNE: branch=1, alu_op=SUB; BNE additionally sets branch_ne=1.
REQ-008 out_wreg SHALL be rd for R-type, rt for I-ALU ops and LW, and 0 otherwise.
REQ-009 out_reg_write SHALL be forced to 0 whenever out_wreg equals 0.
REQ-010 out_rs1 SHALL always be rs; out_rs2 SHALL always be rt.
REQ-011 The immediate SHALL be sign-extended to DATA_W for ADDI, LW, SW, BEQ and BNE, zero-extended for ANDI, ORI and XORI, and 0 for R-type.
REQ-012 An unknown opcode, or an R-type instruction with an unknown funct, SHALL set illegal=1 with all control bits 0; the bundle is still delivered with out_valid=1.
REQ-013 The bundle SHALL be registered: one-cycle latency from the input handshake to out_valid.
REQ-014 Source usage: R-type, SW, BEQ and BNE use rs and rt; I-ALU ops and LW use rs only; illegal instructions use neither.
REQ-015 hazard SHALL be asserted when all of the following hold: HAZARD_EN=1, out_valid=1, out_mem_read=1, out_wreg≠0, and out_wreg matches a used source of in_instr.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-017 When in_valid && in_ready, the output register SHALL load the newly decoded bundle and set out_valid=1.
REQ-018 When out_ready=1 and no input is accepted, out_valid SHALL go to 0; if hazard was high, bubble_cnt SHALL increment, saturating at all-ones.
REQ-019 When out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-020 flush SHALL clear out_valid on the next edge, take priority over all other updates, accept no input, and not count as a bubble.
REQ-021 The resulting load-use sequence is: LW accepted, dependent held one cycle, one bubble emitted, dependent accepted.

Reset
REQ-022 While rst=1, all of the following SHALL be forced immediately: out_valid=0, bubble_cnt=0, and every bundle field=0.
REQ-023 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-024 A reset asserted mid-stall SHALL discard the held and registered instructions; no bubble SHALL be counted.

Structure
REQ-025 Opcode, funct and alu_op encodings SHALL reside in shared package ctrl_pkg.
REQ-026 Combinational decoding SHALL be placed in sub-module decode_comb; decode_stage holds the register, handshake, hazard logic and counter.

Verification
REQ-027 Send 0x00221820 (ADD r3,r1,r2) with out_ready=1 → next cycle out_valid=1, alu_op=000, reg_write=1, wreg=3, rs1=1, rs2=2.
REQ-028 Send 0x2001FFFF (ADDI) then 0x3401FFFF (ORI) → imm=0xFFFF_FFFF_FFFF_FFFF, then 0x0000_0000_0000_FFFF.
REQ-029 Send 0x8C250004 (LW r5) followed by 0x00A23020 (ADD using r5) → in_ready=0 for one cycle, one out_valid=0 bubble, bubble_cnt=1, ADD delivered one cycle later.
REQ-030 Hold out_ready=0 for 3 cycles with a bundle present → outputs stable and in_ready=0; with HAZARD_EN=0 the REQ-029 sequence produces no bubble.
REQ-031 Send 0xFC000000 → illegal=1 and all control bits 0; send 0x00000020 (ADD to r0) → reg_write=0.
REQ-032 Assert flush alongside in_valid → no input accepted and out_valid=0 next cycle; assert rst mid-stall → outputs cleared immediately and bubble_cnt=0.
